// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Comparator result codes as {gt, eq, lt}
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  function automatic logic [31:0] width_max(input int unsigned w);
    width_max = (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sar_window_update.sv
// Combinational search-window narrowing: next lo/hi and terminal classification
// for one comparator result against the current guess.
module sar_window_update
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] guess,
  input  logic [2:0]       code,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next,
  output logic             match,
  output logic             exhausted,
  output logic             illegal
);

  // Bound checks against lo/hi keep guess+1 / guess-1 from wrapping
  always_comb begin
    lo_next   = lo;
    hi_next   = hi;
    match     = 1'b0;
    exhausted = 1'b0;
    illegal   = 1'b0;
    case (code)
      CMP_EQ: match = 1'b1;
      CMP_GT: begin
        if (guess == hi) begin
          exhausted = 1'b1;
        end else begin
          lo_next = guess + WIDTH'(1);
        end
      end
      CMP_LT: begin
        if (guess == lo) begin
          exhausted = 1'b1;
        end else begin
          hi_next = guess - WIDTH'(1);
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sar_search_4.sv
// Successive-approximation search controller driving comparator operand B.
// Optional probe counter output enabled by defining SAR_SEARCH_PROBE_CNT_EN.
module sar_search_4
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gt_i,
  input  logic             eq_i,
  input  logic             lt_i,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef SAR_SEARCH_PROBE_CNT_EN
  ,
  output logic [7:0]       probes
`endif
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(width_max(WIDTH));

  state_t           state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] hi_next;
  logic             match;
  logic             exhausted;
  logic             illegal;

  // Sum is one bit wider so the midpoint never loses the carry
  assign sum   = {1'b0, lo} + {1'b0, hi};
  assign guess = sum[WIDTH:1];

  sar_window_update #(.WIDTH(WIDTH)) u_window (
    .lo        (lo),
    .hi        (hi),
    .guess     (guess),
    .code      ({gt_i, eq_i, lt_i}),
    .lo_next   (lo_next),
    .hi_next   (hi_next),
    .match     (match),
    .exhausted (exhausted),
    .illegal   (illegal)
  );

  // Search FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= {WIDTH{1'b0}};
      hi     <= MAX;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= {WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lo    <= {WIDTH{1'b0}};
            hi    <= MAX;
            busy  <= 1'b1;
            state <= PROBE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        PROBE: begin
          if (illegal || match || exhausted) begin
            err    <= illegal;
            found  <= match;
            result <= guess;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            lo    <= lo_next;
            hi    <= hi_next;
            busy  <= 1'b1;
            state <= PROBE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SAR_SEARCH_PROBE_CNT_EN
  // Probe count: cleared on accepted start, saturating count of PROBE edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probes <= 8'd0;
    end else if (state == IDLE && start) begin
      probes <= 8'd0;
    end else if (state == PROBE && probes != 8'd255) begin
      probes <= probes + 8'd1;
    end else begin
      probes <= probes;
    end
  end
`endif

endmodule

// File: tb/tb_sar_search_4.sv
// Randomized self-checking bench for sar_search_4 with a behavioural binary-search model.
module tb_sar_search_4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       gt_i, eq_i, lt_i;
  logic [3:0] guess;
  logic       busy, done, found, err;
  logic [3:0] result;
`ifdef SAR_SEARCH_PROBE_CNT_EN
  logic [7:0] probes;
`endif

  int total = 0;
  int bad = 0;

  // mode 0: real comparator, 1: always lt, 2: gt+eq, 3: no flags
  logic [3:0] target = 4'd0;
  int         mode = 0;

  int exp_q[$];
  bit exp_found, exp_err;
  int exp_result;

  sar_search_4 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .gt_i   (gt_i),
    .eq_i   (eq_i),
    .lt_i   (lt_i),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result)
`ifdef SAR_SEARCH_PROBE_CNT_EN
    ,
    .probes (probes)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       {gt_i, eq_i, lt_i} = 3'b001;
      2:       {gt_i, eq_i, lt_i} = 3'b110;
      3:       {gt_i, eq_i, lt_i} = 3'b000;
      default: {gt_i, eq_i, lt_i} = {target > guess, target == guess, target < guess};
    endcase
  end

  // Reference: midpoint binary search over integers with the same flag source
  task automatic model(input int tgt, input int md);
    int lo, hi, g, n;
    bit g_f, e_f, l_f;
    lo = 0; hi = 15;
    exp_q.delete();
    exp_found = 0; exp_err = 0; exp_result = 0;
    for (int k = 0; k < 20; k++) begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      case (md)
        1: begin g_f = 0; e_f = 0; l_f = 1; end
        2: begin g_f = 1; e_f = 1; l_f = 0; end
        3: begin g_f = 0; e_f = 0; l_f = 0; end
        default: begin g_f = (tgt > g); e_f = (tgt == g); l_f = (tgt < g); end
      endcase
      n = int'(g_f) + int'(e_f) + int'(l_f);
      exp_result = g;
      if (n != 1) begin exp_err = 1; break; end
      if (e_f) begin exp_found = 1; break; end
      if (g_f) begin
        if (g == hi) break;
        lo = g + 1;
      end else begin
        if (g == lo) break;
        hi = g - 1;
      end
    end
  endtask

  task automatic run_search(input int tgt, input int md, input bit hold_start, input string name);
    int  idx;
    int  want;
    bit  seen_done;
    model(tgt, md);
    target = 4'(tgt);
    mode   = md;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = hold_start;
    idx = 0;
    seen_done = 0;
    for (int c = 0; c < 12 && !seen_done; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen_done = 1;
      end else begin
        want = (idx < exp_q.size()) ? exp_q[idx] : -1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy: got %b want 1 (probe %0d)", name, busy, idx); end
        total++;
        if (int'(guess) != want) begin bad++; $display("FAIL %s guess[%0d]: got %0d want %0d", name, idx, guess, want); end
        idx++;
      end
    end
    total++;
    if (!seen_done) begin bad++; $display("FAIL %s timeout: done never seen, want done after %0d probes", name, exp_q.size()); end
    total++;
    if (idx != exp_q.size()) begin bad++; $display("FAIL %s probe_count: got %0d want %0d", name, idx, exp_q.size()); end
    total++;
    if (found !== exp_found) begin bad++; $display("FAIL %s found: got %b want %b", name, found, exp_found); end
    total++;
    if (err !== exp_err) begin bad++; $display("FAIL %s err: got %b want %b", name, err, exp_err); end
    total++;
    if (int'(result) != exp_result) begin bad++; $display("FAIL %s result: got %0d want %0d", name, result, exp_result); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
    if (md == 0) begin
      total++;
      if (found !== 1'b1 || int'(result) != tgt || idx > 5) begin
        bad++; $display("FAIL %s direct: found=%b result=%0d probes=%0d want 1/%0d/<=5", name, found, result, idx, tgt);
      end
    end
`ifdef SAR_SEARCH_PROBE_CNT_EN
    total++;
    if (int'(probes) != exp_q.size()) begin bad++; $display("FAIL %s probes_out: got %0d want %0d", name, probes, exp_q.size()); end
`endif
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s pulse_end: done=%b busy=%b want 0/0", name, done, busy); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s no_restart: busy=%b want 0", name, busy); end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++;
    if ({busy, done, found, err} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, found, err}); end
    total++;
    if (result !== 4'd0 || guess !== 4'd7) begin bad++; $display("FAIL reset_values: result=%0d guess=%0d want 0/7", result, guess); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_search(11, 0, 1'b0, "t11");
    run_search(0, 0, 1'b0, "t0");
    run_search(15, 0, 1'b0, "t15");
    run_search(5, 1, 1'b0, "all_lt");
    run_search(9, 2, 1'b1, "gt_eq");
    run_search(9, 3, 1'b0, "no_flags");
    run_search(15, 0, 1'b1, "t15_start_held");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_search(int'($urandom_range(0, 15)), (i % 5 == 4) ? int'($urandom_range(1, 3)) : 0,
                 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  task automatic test_mid_reset();
    target = 4'd15;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || guess !== 4'd7) begin
      bad++; $display("FAIL mid_reset: busy=%b done=%b found=%b guess=%0d want 0/0/0/7", busy, done, found, guess);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL mid_reset_done: got %b want 0", done); end
    end
    rst = 1'b0;
    run_search(15, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
